// File: rtl/bp_table_arbiter.sv
// bp_table_arbiter: arbitrates a single-ported branch-predictor table between
// fetch-side lookups and retire-side updates. Updates are held in a small FIFO
// and applied as a read-modify-write of a 2-bit saturating counter. The table
// is cleared after reset.
// Optional feature macro: BP_STATS_EN (adds lookup / taken-prediction counters).
// Entry layout, MSB to LSB: {valid, tag, target, ctr[1:0]}.

`ifndef XLEN
`define XLEN 32
`endif

module bp_table_arbiter #(
    parameter int IDX_BITS   = 5,
    parameter int TAG_BITS   = 8,
    parameter int UQ_DEPTH   = 4,
    parameter int STARVE_MAX = 3,
    localparam int XL = `XLEN,
    localparam int E  = 1 + TAG_BITS + XL + 2,
    localparam int CW = $clog2(UQ_DEPTH) + 1,
    localparam int PW = $clog2(UQ_DEPTH),
    localparam int SW = $clog2(STARVE_MAX + 1) + 1,
    localparam int KW = IDX_BITS + TAG_BITS
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_lu_req,
    input  logic [XL-1:0]       i_lu_pc,
    output logic                o_lu_gnt,
    output logic                o_lu_resp_valid,
    output logic                o_lu_taken,
    output logic [XL-1:0]       o_lu_target,
    input  logic                i_up_valid,
    output logic                o_up_ready,
    input  logic [XL-1:0]       i_up_pc,
    input  logic [XL-1:0]       i_up_target,
    input  logic                i_up_taken,
    output logic                o_tbl_en,
    output logic                o_tbl_we,
    output logic [IDX_BITS-1:0] o_tbl_idx,
    output logic [E-1:0]        o_tbl_wdata,
    input  logic [E-1:0]        i_tbl_rdata,
    output logic [CW-1:0]       o_uq_count
`ifdef BP_STATS_EN
    ,output logic [31:0]        o_stat_lookups
    ,output logic [31:0]        o_stat_taken
`endif
);

    localparam logic [1:0] S_CLEAR  = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_UPD_WR = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [IDX_BITS-1:0] r_clr_idx;

    // Update queue; only the index/tag bits of the PC are needed downstream.
    logic [KW-1:0]       r_uq_key [UQ_DEPTH];
    logic [XL-1:0]       r_uq_tgt [UQ_DEPTH];
    logic                r_uq_tk  [UQ_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [SW-1:0]       r_starve;

    logic                r_resp_pend;
    logic [XL-1:0]       r_pc_q;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_force;
    logic                w_gnt;
    logic                w_en;
    logic                w_we;
    logic [IDX_BITS-1:0] w_idx;
    logic [E-1:0]        w_wdata;

    logic [KW-1:0]       w_up_key;
    logic                w_unused_up_pc;
    logic [IDX_BITS-1:0] w_head_idx;
    logic [TAG_BITS-1:0] w_head_tag;
    logic [XL-1:0]       w_head_tgt;
    logic                w_head_tk;

    logic                w_rd_valid;
    logic [TAG_BITS-1:0] w_rd_tag;
    logic [XL-1:0]       w_rd_tgt;
    logic [1:0]          w_rd_ctr;
    logic                w_up_hit;
    logic [1:0]          w_new_ctr;
    logic                w_lu_hit;
    logic                w_lu_taken;

    assign w_up_key       = i_up_pc[KW+1:2];
    assign w_unused_up_pc = ^{i_up_pc[XL-1:KW+2], i_up_pc[1:0]};

    assign w_full  = (r_count == CW'(UQ_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_up_valid && !w_full;

    assign w_head_idx = r_uq_key[r_rd_ptr][IDX_BITS-1:0];
    assign w_head_tag = r_uq_key[r_rd_ptr][KW-1:IDX_BITS];
    assign w_head_tgt = r_uq_tgt[r_rd_ptr];
    assign w_head_tk  = r_uq_tk[r_rd_ptr];

    assign w_rd_valid = i_tbl_rdata[E-1];
    assign w_rd_tag   = i_tbl_rdata[E-2 -: TAG_BITS];
    assign w_rd_tgt   = i_tbl_rdata[XL+1:2];
    assign w_rd_ctr   = i_tbl_rdata[1:0];

    assign w_up_hit = w_rd_valid && (w_rd_tag == w_head_tag);

    // Saturating 2-bit counter step in the resolved direction.
    always_comb begin
        w_new_ctr = w_rd_ctr;
        if (w_head_tk) begin
            if (w_rd_ctr != 2'b11) w_new_ctr = w_rd_ctr + 2'b01;
        end else begin
            if (w_rd_ctr != 2'b00) w_new_ctr = w_rd_ctr - 2'b01;
        end
    end

    // Table port arbitration and next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        w_en        = 1'b0;
        w_we        = 1'b0;
        w_idx       = '0;
        w_wdata     = '0;
        w_gnt       = 1'b0;
        w_force     = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_en  = 1'b1;
                w_we  = 1'b1;
                w_idx = r_clr_idx;
                if (&r_clr_idx) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!w_empty && (!i_lu_req || w_full ||
                                 r_starve == SW'(STARVE_MAX))) begin
                    w_force     = 1'b1;
                    w_en        = 1'b1;
                    w_idx       = w_head_idx;
                    w_state_nxt = S_UPD_WR;
                end else if (i_lu_req) begin
                    w_gnt = 1'b1;
                    w_en  = 1'b1;
                    w_idx = i_lu_pc[IDX_BITS+1:2];
                end
            end
            S_UPD_WR: begin
                w_pop       = 1'b1;
                w_idx       = w_head_idx;
                w_state_nxt = S_IDLE;
                if (w_up_hit) begin
                    w_en    = 1'b1;
                    w_we    = 1'b1;
                    w_wdata = {1'b1, w_rd_tag,
                               (w_head_tk ? w_head_tgt : w_rd_tgt), w_new_ctr};
                end else if (w_head_tk) begin
                    // Miss on a taken branch allocates in weakly-taken.
                    w_en    = 1'b1;
                    w_we    = 1'b1;
                    w_wdata = {1'b1, w_head_tag, w_head_tgt, 2'b10};
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // State register and clear-index walker.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + IDX_BITS'(1);
        end
    end

    // Queue storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_uq_key[r_wr_ptr] <= w_up_key;
            r_uq_tgt[r_wr_ptr] <= i_up_target;
            r_uq_tk[r_wr_ptr]  <= i_up_taken;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation counter: lookups granted while updates wait.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_starve <= '0;
        end else if (w_force) begin
            r_starve <= '0;
        end else if (w_gnt && !w_empty && r_starve != SW'(STARVE_MAX)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Lookup response pipeline: remember the granted PC for tag compare.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_resp_pend <= 1'b0;
            r_pc_q      <= '0;
        end else begin
            r_resp_pend <= w_gnt;
            if (w_gnt) r_pc_q <= i_lu_pc;
        end
    end

    assign w_lu_hit   = w_rd_valid && (w_rd_tag == r_pc_q[KW+1:IDX_BITS+2]);
    assign w_lu_taken = r_resp_pend && w_lu_hit && w_rd_ctr[1];

    assign o_lu_gnt        = w_gnt;
    assign o_lu_resp_valid = r_resp_pend;
    assign o_lu_taken      = w_lu_taken;
    assign o_lu_target     = !r_resp_pend ? '0 :
                             (w_lu_taken ? w_rd_tgt : r_pc_q + XL'(4));
    assign o_up_ready      = !w_full;
    // The table must see no access while reset is held.
    assign o_tbl_en        = w_en && !i_reset;
    assign o_tbl_we        = w_we && !i_reset;
    assign o_tbl_idx       = w_idx;
    assign o_tbl_wdata     = w_wdata;
    assign o_uq_count      = r_count;

`ifdef BP_STATS_EN
    // Prediction statistics; both counters wrap.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_stat_lookups <= '0;
            o_stat_taken   <= '0;
        end else if (r_resp_pend) begin
            o_stat_lookups <= o_stat_lookups + 32'd1;
            if (w_lu_taken) o_stat_taken <= o_stat_taken + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_table_arbiter.sv
// Directed bench for bp_table_arbiter with a behavioral single-port table.
module tb_bp_table_arbiter;
    localparam int E = 1 + 8 + 32 + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          lu_req = 1'b0;
    logic [31:0]   lu_pc = '0;
    logic          lu_gnt;
    logic          lu_resp_valid;
    logic          lu_taken;
    logic [31:0]   lu_target;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [31:0]   up_pc = '0;
    logic [31:0]   up_target = '0;
    logic          up_taken = 1'b0;
    logic          tbl_en;
    logic          tbl_we;
    logic [4:0]    tbl_idx;
    logic [E-1:0]  tbl_wdata;
    logic [E-1:0]  tbl_rdata = '0;
    logic [2:0]    uq_count;

    logic [E-1:0]  mem [32];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clock = ~clock;

    bp_table_arbiter dut (
        .i_clock(clock), .i_reset(reset),
        .i_lu_req(lu_req), .i_lu_pc(lu_pc), .o_lu_gnt(lu_gnt),
        .o_lu_resp_valid(lu_resp_valid), .o_lu_taken(lu_taken), .o_lu_target(lu_target),
        .i_up_valid(up_valid), .o_up_ready(up_ready), .i_up_pc(up_pc),
        .i_up_target(up_target), .i_up_taken(up_taken),
        .o_tbl_en(tbl_en), .o_tbl_we(tbl_we), .o_tbl_idx(tbl_idx),
        .o_tbl_wdata(tbl_wdata), .i_tbl_rdata(tbl_rdata), .o_uq_count(uq_count)
    );

    // Single-port table: read data appears the cycle after a read.
    always @(posedge clock) begin
        if (tbl_en) begin
            if (tbl_we) mem[tbl_idx] <= tbl_wdata;
            else        tbl_rdata    <= mem[tbl_idx];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [E-1:0] entry(input logic [7:0] tag, input logic [31:0] tgt,
                                           input logic [1:0] ctr);
        return {1'b1, tag, tgt, ctr};
    endfunction

    task automatic do_update(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                             input logic tk, input int exp_wr, input logic [E-1:0] exp_wd);
        int nwr;
        logic [E-1:0] last;
        nwr  = 0;
        last = '0;
        up_valid = 1'b1; up_pc = pc; up_target = tgt; up_taken = tk;
        @(negedge clock);
        up_valid = 1'b0;
        for (int k = 0; k < 10 && uq_count != 0; k++) begin
            if (tbl_en && tbl_we) begin
                nwr++;
                last = tbl_wdata;
            end
            @(negedge clock);
        end
        check({tag, "_drain"}, uq_count, 0);
        check({tag, "_nwr"}, nwr, exp_wr);
        if (exp_wr > 0) check({tag, "_wdata"}, last, exp_wd);
    endtask

    task automatic do_lookup(input string tag, input logic [31:0] pc, input logic exp_tk,
                             input logic [31:0] exp_tgt);
        lu_req = 1'b1; lu_pc = pc;
        #1;
        check({tag, "_gnt"}, lu_gnt, 1);
        @(negedge clock);
        lu_req = 1'b0;
        check({tag, "_rv"}, lu_resp_valid, 1);
        check({tag, "_taken"}, lu_taken, exp_tk);
        check({tag, "_target"}, lu_target, exp_tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, gap, maxgap, found;
        logic [2:0] prev;

        repeat (3) @(negedge clock);
        check("rst_gnt", lu_gnt, 0);
        check("rst_rv", lu_resp_valid, 0);
        check("rst_taken", lu_taken, 0);
        check("rst_target", lu_target, 0);
        check("rst_up_ready", up_ready, 1);
        check("rst_tbl_en", tbl_en, 0);
        check("rst_tbl_we", tbl_we, 0);
        check("rst_count", uq_count, 0);

        // Clear sweep with a lookup held pending; it must not be granted.
        reset = 1'b0; lu_req = 1'b1; lu_pc = 32'h100;
        #1;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (!(tbl_en && tbl_we && tbl_idx == i[4:0] && tbl_wdata == '0 && !lu_gnt)) bad++;
            @(negedge clock);
        end
        check("clear_bad_cycles", bad, 0);
        check("cleared_lu_gnt", lu_gnt, 1);
        @(negedge clock);
        lu_req = 1'b0;
        check("cleared_rv", lu_resp_valid, 1);
        check("cleared_taken", lu_taken, 0);
        check("cleared_target", lu_target, 32'h104);

        // pc 0x100: idx 0, tag 2.
        do_update("upd_miss_tk", 32'h100, 32'h200, 1'b1, 1, entry(8'h02, 32'h200, 2'b10));
        do_lookup("lu_tk", 32'h100, 1'b1, 32'h200);
        do_update("upd_nt1", 32'h100, 32'h999, 1'b0, 1, entry(8'h02, 32'h200, 2'b01));
        do_update("upd_nt2", 32'h100, 32'h0, 1'b0, 1, entry(8'h02, 32'h200, 2'b00));
        do_lookup("lu_nt", 32'h100, 1'b0, 32'h104);
        do_update("upd_nt_sat", 32'h100, 32'h0, 1'b0, 1, entry(8'h02, 32'h200, 2'b00));
        // pc 0x3000 aliases idx 0 with tag 0x60: not-taken miss writes nothing.
        do_update("upd_miss_nt", 32'h3000, 32'h7000, 1'b0, 0, '0);
        do_update("upd_hit_tk1", 32'h100, 32'h300, 1'b1, 1, entry(8'h02, 32'h300, 2'b01));
        do_lookup("lu_weak", 32'h100, 1'b0, 32'h104);
        do_update("upd_hit_tk2", 32'h100, 32'h300, 1'b1, 1, entry(8'h02, 32'h300, 2'b10));
        do_update("upd_hit_tk3", 32'h100, 32'h300, 1'b1, 1, entry(8'h02, 32'h300, 2'b11));
        do_update("upd_tk_sat", 32'h100, 32'h300, 1'b1, 1, entry(8'h02, 32'h300, 2'b11));
        do_lookup("lu_strong", 32'h100, 1'b1, 32'h300);
        do_lookup("lu_alias", 32'h3000, 1'b0, 32'h3004);
        do_update("upd_replace", 32'h3000, 32'h7000, 1'b1, 1, entry(8'h60, 32'h7000, 2'b10));
        do_lookup("lu_evicted", 32'h100, 1'b0, 32'h104);
        do_lookup("lu_new", 32'h3000, 1'b1, 32'h7000);

        // Fill the queue while fetch keeps requesting; the fifth push is dropped.
        lu_req = 1'b1; lu_pc = 32'h100;
        for (int i = 0; i < 5; i++) begin
            up_valid = 1'b1; up_pc = 32'h104 + 32'(4 * i);
            up_target = 32'h1000 * 32'(i + 1); up_taken = 1'b1;
            if (i == 4) begin
                check("fill_up_ready", up_ready, 0);
                check("fill_count", uq_count, 4);
            end
            @(negedge clock);
        end
        up_valid = 1'b0;
        gap = 0; maxgap = 0; prev = uq_count;
        for (int k = 0; k < 60 && uq_count != 0; k++) begin
            @(negedge clock);
            gap++;
            if (uq_count < prev) begin
                if (gap > maxgap) maxgap = gap;
                gap = 0;
            end
            prev = uq_count;
        end
        lu_req = 1'b0;
        check("fill_drain", uq_count, 0);
        check("fill_gap_le_5", (maxgap > 0 && maxgap <= 5), 1);
        do_lookup("lu_fill_a", 32'h104, 1'b1, 32'h1000);
        do_lookup("lu_fill_d", 32'h110, 1'b1, 32'h4000);
        do_lookup("lu_dropped", 32'h114, 1'b0, 32'h118);

        // Reset in UPD_WR with three updates queued (idx 16..18).
        lu_req = 1'b1; lu_pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            up_valid = 1'b1; up_pc = 32'h140 + 32'(4 * i);
            up_target = 32'h8000; up_taken = 1'b1;
            @(negedge clock);
        end
        up_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            if (tbl_en && !tbl_we && !lu_gnt) found = 1;
            else @(negedge clock);
        end
        check("rw_force_seen", found, 1);
        @(negedge clock);
        check("rw_count", uq_count, 3);
        check("rw_we_pending", tbl_we, 1);
        check("rw_idx", tbl_idx, 5'd16);
        #1 reset = 1'b1;
        #1;
        check("rw_rst_count", uq_count, 0);
        check("rw_rst_rv", lu_resp_valid, 0);
        check("rw_rst_tbl_en", tbl_en, 0);
        check("rw_rst_up_ready", up_ready, 1);
        lu_req = 1'b0;
        @(negedge clock);
        check("rw_rst_hold_en", tbl_en, 0);
        reset = 1'b0;
        #1;
        check("rw_clear_start_idx", tbl_idx, 0);
        check("rw_clear_start_we", tbl_we, 1);
        repeat (32) @(negedge clock);
        do_lookup("lu_after_rst", 32'h140, 1'b0, 32'h144);
        do_lookup("lu_after_rst0", 32'h3000, 1'b0, 32'h3004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
